// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, FSM states,
// instruction classes, ALUop and PC-source codes.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_NEG  = 2'b10;
  localparam logic [1:0] ALU_SUB  = 2'b11;

  localparam logic [1:0] PC_PLUS1 = 2'b00;
  localparam logic [1:0] PC_REG   = 2'b01;
  localparam logic [1:0] PC_MEM   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_SVPC = 4'd1,
    C_LD   = 4'd2,
    C_ST   = 4'd3,
    C_ADD  = 4'd4,
    C_INC  = 4'd5,
    C_NEG  = 4'd6,
    C_SUB  = 4'd7,
    C_J    = 4'd8,
    C_BRZ  = 4'd9,
    C_JM   = 4'd10,
    C_BRN  = 4'd11
  } iclass_e;

  function automatic logic is_mem_read(input iclass_e c);
    return (c == C_LD) || (c == C_JM);
  endfunction

endpackage

// File: rtl/multicycle_control_opcode_decoder.sv
// Combinational opcode classifier: maps the IR opcode to an instruction class,
// its ALUop/immediate controls, and an illegal-opcode flag.
module opcode_decoder
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_e             iclass,
  output logic [1:0]          aluop,
  output logic                imme,
  output logic                illegal
);

  logic [3:0] op4_s;
  logic       upper_s;
  logic       op_bad_s;

  assign op4_s   = opcode[3:0];
  assign upper_s = |(opcode >> 4);
  assign illegal = upper_s | op_bad_s;

  // Low-nibble class lookup; unlisted encodings are illegal.
  always_comb begin
    iclass   = C_NOP;
    aluop    = ALU_PASS;
    imme     = 1'b0;
    op_bad_s = 1'b0;
    case (op4_s)
      OP_NOP:  iclass = C_NOP;
      OP_SVPC: begin iclass = C_SVPC; aluop = ALU_ADD; end
      OP_LD:   iclass = C_LD;
      OP_ST:   iclass = C_ST;
      OP_ADD:  begin iclass = C_ADD; aluop = ALU_ADD; end
      OP_INC:  begin iclass = C_INC; aluop = ALU_ADD; imme = 1'b1; end
      OP_NEG:  begin iclass = C_NEG; aluop = ALU_NEG; end
      OP_SUB:  begin iclass = C_SUB; aluop = ALU_SUB; end
      OP_J:    iclass = C_J;
      OP_BRZ:  iclass = C_BRZ;
      OP_JM:   iclass = C_JM;
      OP_BRN:  iclass = C_BRN;
      default: op_bad_s = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with handshake
// stalls, memory timeout abort and a sticky illegal flag.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic                zero_flag,
  input  logic                neg_flag,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                regWrite,
  output logic                imme,
  output logic                PCtoReg,
  output logic                memToReg,
  output logic                memRead,
  output logic                memWrite,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                illegal,
  output logic [2:0]          state
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int TO_M1 = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  state_e     state_r;
  iclass_e    class_r;
  logic [1:0] aluop_r;
  logic       imme_r;
  logic [CNT_W-1:0] cnt_r;
  logic       illegal_r;

  iclass_e    dec_class_s;
  logic [1:0] dec_aluop_s;
  logic       dec_imme_s;
  logic       dec_illegal_s;
  logic       timeout_s;

  logic       ir_write_s, pc_write_s, reg_write_s, imme_s, pc_to_reg_s;
  logic       mem_to_reg_s, mem_read_s, mem_write_s;
  logic [1:0] pc_src_s, aluop_s;

  opcode_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode  (opcode),
    .iclass  (dec_class_s),
    .aluop   (dec_aluop_s),
    .imme    (dec_imme_s),
    .illegal (dec_illegal_s)
  );

  // The final wait cycle is the one where the counter would reach MEM_TIMEOUT.
  assign timeout_s = TO_EN && (cnt_r == CNT_W'(TO_M1));

  // Sequencer state, latched class, MEM wait counter and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      class_r   <= C_NOP;
      aluop_r   <= ALU_PASS;
      imme_r    <= 1'b0;
      cnt_r     <= '0;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (instr_valid) state_r <= S_DECODE;
          else             state_r <= S_FETCH;
        end
        S_DECODE: begin
          class_r <= dec_class_s;
          aluop_r <= dec_aluop_s;
          imme_r  <= dec_imme_s;
          if (dec_illegal_s) begin
            illegal_r <= 1'b1;
            state_r   <= S_HALT;
          end else if (dec_class_s == C_NOP) begin
            state_r <= S_FETCH;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (class_r)
            C_ADD, C_INC, C_NEG, C_SUB, C_SVPC: state_r <= S_WB;
            C_LD, C_ST, C_JM:                   state_r <= S_MEM;
            default:                            state_r <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            cnt_r   <= '0;
            state_r <= (class_r == C_LD) ? S_WB : S_FETCH;
          end else if (timeout_s) begin
            cnt_r     <= '0;
            illegal_r <= 1'b1;
            state_r   <= S_HALT;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_WB:    state_r <= S_FETCH;
        S_HALT:  state_r <= S_HALT;
        default: begin
          illegal_r <= 1'b1;
          state_r   <= S_HALT;
        end
      endcase
    end
  end

  // Moore strobes per state; branch pc_src and MEM exit strobes look at live inputs.
  always_comb begin
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = PC_PLUS1;
    reg_write_s  = 1'b0;
    imme_s       = 1'b0;
    pc_to_reg_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    aluop_s      = ALU_PASS;
    case (state_r)
      S_FETCH:  ir_write_s = instr_valid;
      S_DECODE: pc_write_s = !dec_illegal_s && (dec_class_s == C_NOP);
      S_EXEC: begin
        aluop_s = aluop_r;
        imme_s  = imme_r;
        case (class_r)
          C_J:     begin pc_write_s = 1'b1; pc_src_s = PC_REG; end
          C_BRZ:   begin pc_write_s = 1'b1; pc_src_s = zero_flag ? PC_REG : PC_PLUS1; end
          C_BRN:   begin pc_write_s = 1'b1; pc_src_s = neg_flag ? PC_REG : PC_PLUS1; end
          default: pc_write_s = 1'b0;
        endcase
      end
      S_MEM: begin
        mem_read_s  = is_mem_read(class_r);
        mem_write_s = (class_r == C_ST);
        if (mem_ready && (class_r == C_ST)) begin
          pc_write_s = 1'b1;
        end else if (mem_ready && (class_r == C_JM)) begin
          pc_write_s = 1'b1;
          pc_src_s   = PC_MEM;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = (class_r == C_LD);
        pc_to_reg_s  = (class_r == C_SVPC);
        pc_write_s   = 1'b1;
      end
      default: ir_write_s = 1'b0;
    endcase
  end

  assign ir_write = ir_write_s   & rst_n;
  assign pc_write = pc_write_s   & rst_n;
  assign pc_src   = pc_src_s     & {2{rst_n}};
  assign regWrite = reg_write_s  & rst_n;
  assign imme     = imme_s       & rst_n;
  assign PCtoReg  = pc_to_reg_s  & rst_n;
  assign memToReg = mem_to_reg_s & rst_n;
  assign memRead  = mem_read_s   & rst_n;
  assign memWrite = mem_write_s  & rst_n;
  assign ALUop    = ALUOP_W'(aluop_s) & {ALUOP_W{rst_n}};
  assign illegal  = illegal_r    & rst_n;
  assign state    = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-scenario tasks with hand-computed
// expected strobe vectors.
module tb_multicycle_control;

  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic       im;
    logic       p2r;
    logic       m2r;
    logic       mr;
    logic       mw;
    logic [1:0] alu;
    logic       ill;
  } outs_t;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SH = 3'd5;

  logic       clk, rst_n;
  logic [3:0] opcode;
  logic       instr_valid, mem_ready, zero_flag, neg_flag;
  logic       ir_write, pc_write, regWrite, imme, PCtoReg, memToReg, memRead, memWrite, illegal;
  logic [1:0] pc_src, ALUop;
  logic [2:0] state;
  outs_t      obs, e;
  int         checks = 0;
  int         errors = 0;

  multicycle_control #(.OPCODE_W(4), .ALUOP_W(2), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .zero_flag(zero_flag), .neg_flag(neg_flag),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .regWrite(regWrite),
    .imme(imme), .PCtoReg(PCtoReg), .memToReg(memToReg), .memRead(memRead),
    .memWrite(memWrite), .ALUop(ALUop), .illegal(illegal), .state(state)
  );

  assign obs = {state, ir_write, pc_write, pc_src, regWrite, imme, PCtoReg,
                memToReg, memRead, memWrite, ALUop, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; instr_valid = 1'b1; opcode = 4'b0100;
    mem_ready = 1'b0; zero_flag = 1'b0; neg_flag = 1'b0;
    e = '0; #2; checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_hold got %h exp %h", obs, e); end
    tick; rst_n = 1'b1; instr_valid = 1'b0;
    e = '0; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release got %h exp %h", obs, e); end
  endtask

  task automatic test_add;
    opcode = 4'b0100; instr_valid = 1'b1;
    e = '0; e.irw = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL add_fetch got %h exp %h", obs, e); end
    tick; instr_valid = 1'b0;
    e = '0; e.st = SD; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL add_decode got %h exp %h", obs, e); end
    tick; e = '0; e.st = SE; e.alu = 2'b01; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL add_exec got %h exp %h", obs, e); end
    tick; e = '0; e.st = SW; e.rw = 1'b1; e.pcw = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL add_wb got %h exp %h", obs, e); end
    tick; e = '0; e.st = SF; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL add_cycle5 got %h exp %h", obs, e); end
  endtask

  task automatic test_ld;
    opcode = 4'b1110; instr_valid = 1'b1; mem_ready = 1'b0;
    tick; instr_valid = 1'b0;
    tick; e = '0; e.st = SE; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL ld_exec got %h exp %h", obs, e); end
    tick;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3) ? 1'b1 : 1'b0;
      e = '0; e.st = SM; e.mr = 1'b1; #1; checks++;
      if (obs !== e) begin errors++; $display("FAIL ld_mem%0d got %h exp %h", i, obs, e); end
      tick;
    end
    mem_ready = 1'b0;
    e = '0; e.st = SW; e.rw = 1'b1; e.m2r = 1'b1; e.pcw = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL ld_wb got %h exp %h", obs, e); end
    tick; e = '0; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL ld_done got %h exp %h", obs, e); end
  endtask

  task automatic test_brz;
    opcode = 4'b1001; zero_flag = 1'b1; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    tick; e = '0; e.st = SE; e.pcw = 1'b1; e.pcs = 2'b01; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL brz_taken got %h exp %h", obs, e); end
    tick; zero_flag = 1'b0; instr_valid = 1'b1;
    e = '0; e.irw = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL brz_refetch got %h exp %h", obs, e); end
    tick; instr_valid = 1'b0;
    tick; e = '0; e.st = SE; e.pcw = 1'b1; e.pcs = 2'b00; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL brz_not_taken got %h exp %h", obs, e); end
    tick;
  endtask

  task automatic test_brn;
    opcode = 4'b1011; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    tick; zero_flag = 1'b1; neg_flag = 1'b0;
    e = '0; e.st = SE; e.pcw = 1'b1; e.pcs = 2'b00; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL brn_not_taken got %h exp %h", obs, e); end
    zero_flag = 1'b0; neg_flag = 1'b1;
    e.pcs = 2'b01; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL brn_taken got %h exp %h", obs, e); end
    tick; neg_flag = 1'b0;
    e = '0; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL brn_done got %h exp %h", obs, e); end
  endtask

  task automatic test_jm;
    opcode = 4'b1010; instr_valid = 1'b1; mem_ready = 1'b1;
    tick; instr_valid = 1'b0;
    tick; e = '0; e.st = SE; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL jm_exec got %h exp %h", obs, e); end
    tick; e = '0; e.st = SM; e.mr = 1'b1; e.pcw = 1'b1; e.pcs = 2'b10; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL jm_mem got %h exp %h", obs, e); end
    tick; mem_ready = 1'b0;
    e = '0; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL jm_done got %h exp %h", obs, e); end
  endtask

  task automatic test_back_to_back;
    opcode = 4'b0000; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    e = '0; e.st = SD; e.pcw = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL nop_decode got %h exp %h", obs, e); end
    tick; opcode = 4'b0101; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    tick; e = '0; e.st = SE; e.alu = 2'b01; e.im = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL inc_exec got %h exp %h", obs, e); end
    tick; tick; opcode = 4'b1111; instr_valid = 1'b1;
    e = '0; e.irw = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL svpc_fetch got %h exp %h", obs, e); end
    tick; instr_valid = 1'b0;
    tick; e = '0; e.st = SE; e.alu = 2'b01; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL svpc_exec got %h exp %h", obs, e); end
    tick; e = '0; e.st = SW; e.rw = 1'b1; e.p2r = 1'b1; e.pcw = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL svpc_wb got %h exp %h", obs, e); end
    tick;
  endtask

  task automatic test_st_ready_at_timeout;
    opcode = 4'b0011; instr_valid = 1'b1; mem_ready = 1'b0;
    tick; instr_valid = 1'b0;
    tick; tick;
    for (int i = 0; i < 14; i++) tick;
    mem_ready = 1'b1;
    e = '0; e.st = SM; e.mw = 1'b1; e.pcw = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL st_ready_wins got %h exp %h", obs, e); end
    tick; mem_ready = 1'b0;
    e = '0; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL st_ready_no_halt got %h exp %h", obs, e); end
  endtask

  task automatic test_st_timeout;
    opcode = 4'b0011; instr_valid = 1'b1; mem_ready = 1'b0;
    tick; instr_valid = 1'b0;
    tick; tick;
    for (int i = 0; i < 15; i++) begin
      e = '0; e.st = SM; e.mw = 1'b1; #1; checks++;
      if (obs !== e) begin errors++; $display("FAIL st_wait%0d got %h exp %h", i, obs, e); end
      tick;
    end
    e = '0; e.st = SH; e.ill = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL st_timeout_halt got %h exp %h", obs, e); end
    rst_n = 1'b0;
    tick; rst_n = 1'b1;
  endtask

  task automatic test_illegal;
    opcode = 4'b0001; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    tick; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = '0; e.st = SH; e.ill = 1'b1; #1; checks++;
      if (obs !== e) begin errors++; $display("FAIL illegal_halt%0d got %h exp %h", i, obs, e); end
      tick;
    end
    rst_n = 1'b0;
    e = '0; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL illegal_reset got %h exp %h", obs, e); end
    tick; rst_n = 1'b1; instr_valid = 1'b0;
    e = '0; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL illegal_cleared got %h exp %h", obs, e); end
  endtask

  task automatic test_jm_reset;
    opcode = 4'b1010; instr_valid = 1'b1; mem_ready = 1'b0;
    tick; instr_valid = 1'b0;
    tick; tick; tick;
    e = '0; e.st = SM; e.mr = 1'b1; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL jmr_mem got %h exp %h", obs, e); end
    #1; rst_n = 1'b0;
    e = '0; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL jmr_abort got %h exp %h", obs, e); end
    tick; rst_n = 1'b1;
    tick; e = '0; #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL jmr_after got %h exp %h", obs, e); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_ld;
    test_brz;
    test_brn;
    test_jm;
    test_back_to_back;
    test_st_ready_at_timeout;
    test_st_timeout;
    test_illegal;
    test_jm_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
